// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop sync, 16x oversampling, majority vote, one-byte holding register; UART_RX_PARITY_EN selects 8E1.
// Latency: rx_valid rises DIV*(16*9+10) cycles after start-edge detect (DIV*(16*10+10) with parity).
// Backpressure: none on the line; a byte finishing while rx_valid is unacked is dropped and flagged as overrun.
module uart_rx_ctrl #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_START  = 3'd1;
    localparam logic [2:0]  S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0]  S_PARITY = 3'd3;
`endif
    localparam logic [2:0]  S_STOP   = 3'd4;
    localparam logic [15:0] TICK_MAX = 16'(DIV - 1);

    logic [1:0]  sync_q, sync_d;
    logic        rxs_prev_q, rxs_prev_d;
    logic [2:0]  state_q, state_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  samp_q, samp_d;
    logic [1:0]  smp_q, smp_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        parity_err_q, parity_err_d;
`endif

    logic rxs, tick, decision;

    assign rxs      = sync_q[1];
    assign tick     = (state_q != S_IDLE) && (tick_cnt_q == TICK_MAX);
    // smp_q holds the tick-7 and tick-8 samples; rxs is the tick-9 sample
    assign decision = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

    always_comb begin
        sync_d       = {sync_q[0], UART_RX};
        rxs_prev_d   = rxs;
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        samp_d       = samp_q;
        smp_d        = smp_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif

        if (rx_ack) begin
            rx_valid_d   = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end

        if (state_q == S_IDLE) begin
            tick_cnt_d = 16'd0;
        end else begin
            tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        end

        if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd7) smp_d[0] = rxs;
            if (samp_q == 4'd8) smp_d[1] = rxs;
        end

        case (state_q)
            S_IDLE: begin
                samp_d = 4'd0;
                // A falling edge is required, so a line stuck low cannot restart frames
                if (rxs_prev_q && !rxs) state_d = S_START;
            end
            S_START: begin
                if (tick && samp_q == 4'd9 && decision) state_d = S_IDLE;
                if (tick && samp_q == 4'd15) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick && samp_q == 4'd9) shift_d = {decision, shift_q[7:1]};
                if (tick && samp_q == 4'd15) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick && samp_q == 4'd9) par_bad_d = ^{decision, shift_q};
                if (tick && samp_q == 4'd15) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave at mid-stop-bit so the next start edge is never missed
                if (tick && samp_q == 4'd9) begin
                    state_d = S_IDLE;
                    if (!decision) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else if (!rx_valid_q || rx_ack) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            rxs_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            tick_cnt_q   <= 16'd0;
            samp_q       <= 4'd0;
            smp_q        <= 2'b00;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            rxs_prev_q   <= rxs_prev_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            smp_q        <= smp_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at DIV=1: directed scenarios plus random frames against a frame-level register model.
module tb_uart_rx_ctrl;

    localparam int DIV = 1;
    localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // load edge counted from the first posedge after the line falls: 2 sync + 1 detect - 1
    localparam int LAT_P0 = DIV * (16 * (NBITS - 1) + 10) + 2;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       UART_RX = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    always #5 sysclk = ~sysclk;

    uart_rx_ctrl #(.DIV(DIV)) dut (
        .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_ovr, m_perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rx_data"},    32'(rx_data),    32'(m_data));
        chk({tag, ".rx_valid"},   32'(rx_valid),   32'(m_valid));
        chk({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    // Register-level effect of one finished frame, optionally with an ack landing on the same cycle
    task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok,
                               input logic ack_same);
        logic ld;
        ld = 1'b0;
        if (!stop_ok)                  m_ferr = 1'b1;
        else if (!par_ok)              m_perr = 1'b1;
        else if (!m_valid || ack_same) ld = 1'b1;
        else                           m_ovr = 1'b1;
        if (ack_same) begin
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end
        if (ld) begin
            m_data = d; m_valid = 1'b1;
        end
    endtask

    // Caller is at a negedge; the line is driven one bit per BIT cycles
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        UART_RX = 1'b0;
        repeat (BIT) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (BIT) @(negedge sysclk);
        end
`ifdef UART_RX_PARITY_EN
        UART_RX = par_b;
        repeat (BIT) @(negedge sysclk);
`else
        if (par_b === 1'bx) UART_RX = 1'b1;
`endif
        UART_RX = stop_b;
        repeat (BIT) @(negedge sysclk);
        UART_RX = 1'b1;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] d, input logic stop_ok,
                            input logic par_ok);
        logic pb;
        pb = par_ok ? (^d) : ~(^d);
        send_frame(d, stop_ok, pb);
        model_frame(d, stop_ok, par_ok, 1'b0);
        repeat (4) @(negedge sysclk);
        check_all(tag);
    endtask

    task automatic do_ack(input string tag);
        rx_ack = 1'b1;
        @(negedge sysclk);
        rx_ack = 1'b0;
        m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] d;
        logic       s_ok, p_ok;
        model_reset();
        repeat (5) @(negedge sysclk);
        check_all("reset");
        reset = 1'b1;
        repeat (3) @(negedge sysclk);

        // First byte with latency measurement
        lat = -1;
        d = 8'hA5;
        fork
            send_frame(d, 1'b1, ^d);
            begin
                int k;
                k = 0;
                while (k < 400 && lat < 0) begin
                    @(posedge sysclk); #1;
                    if (rx_valid) lat = k;
                    k++;
                end
            end
        join
        chk("latency", 32'((lat >= LAT_P0 - 1 && lat <= LAT_P0 + 1) ? LAT_P0 : lat), 32'(LAT_P0));
        model_frame(d, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge sysclk);
        check_all("a5");

        // Overrun on back-to-back frames, then ack
        do_ack("ack0");
        do_frame("b2b_3c", 8'h3C, 1'b1, 1'b1);
        do_frame("b2b_c3", 8'hC3, 1'b1, 1'b1);
        do_ack("ack_ovr");

        // Ack in the exact load cycle while overrun is pending
        do_frame("pre_5a", 8'h5A, 1'b1, 1'b1);
        do_frame("pre_77", 8'h77, 1'b1, 1'b1);
        d = 8'hA3;
        fork
            send_frame(d, 1'b1, ^d);
            begin
                repeat (LAT_P0) @(posedge sysclk);
                @(negedge sysclk);
                rx_ack = 1'b1;
                @(negedge sysclk);
                rx_ack = 1'b0;
            end
        join
        model_frame(d, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge sysclk);
        check_all("collide");

        // False start, then a clean frame proves the receiver is idle again
        do_ack("ack1");
        UART_RX = 1'b0;
        repeat (4 * DIV) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (40) @(negedge sysclk);
        check_all("glitch");
        do_frame("post_glitch", 8'h9E, 1'b1, 1'b1);

        // Bad stop bit
        do_ack("ack2");
        do_frame("ferr_55", 8'h55, 1'b0, 1'b1);
        do_ack("ack3");

        // Break: one framing error, no re-triggering while held low
        UART_RX = 1'b0;
        repeat (200) @(negedge sysclk);
        model_frame(8'h00, 1'b0, 1'b1, 1'b0);
        check_all("break");
        do_ack("ack_break");
        repeat (300) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (20) @(negedge sysclk);
        check_all("break_once");

        // Mid-frame reset with a byte and a flag pending
        do_frame("pre_rst_a", 8'h81, 1'b1, 1'b1);
        do_frame("pre_rst_b", 8'h42, 1'b1, 1'b1);
        d = 8'hFF;
        fork
            send_frame(d, 1'b1, ^d);
            begin
                repeat (BIT * 5 + 8) @(negedge sysclk);
                reset = 1'b0;
                #1;
                model_reset();
                check_all("midrst");
                repeat (3) @(negedge sysclk);
                reset = 1'b1;
            end
        join
        repeat (4) @(negedge sysclk);
        check_all("post_rst_idle");
        do_frame("post_rst_12", 8'h12, 1'b1, 1'b1);

`ifdef UART_RX_PARITY_EN
        do_ack("ack_p");
        do_frame("par_good_07", 8'h07, 1'b1, 1'b1);
        do_frame("par_bad_07", 8'h07, 1'b1, 1'b0);
`endif

        // Random frames with random errors and random acks
        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom);
            s_ok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            p_ok = ($urandom_range(0, 5) != 0);
`else
            p_ok = 1'b1;
`endif
            do_frame($sformatf("rnd%0d", n), d, s_ok, p_ok);
            if ($urandom_range(0, 1) == 1) do_ack($sformatf("rnd_ack%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive front-end for the single-cycle MIPS system: it oversamples the board `UART_RX` pin, reassembles 8N1 frames and holds one byte with status flags. The Peripheral block's memory-mapped UART receive register reads that byte, and the byte also drives the receive-data LED digit and the UART receive interrupt source. The block runs on the undivided board clock so its baud timing does not depend on the CPU clock divider.

## Interface
- `CLK_FREQ`, 100000000: `sysclk` frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DIV`, `CLK_FREQ/(BAUD*16)` (integer division): `sysclk` cycles per oversample tick; legal range 1..65535.

- `sysclk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; when `reset`=0, all state is cleared immediately.
- `UART_RX`  in  1  serial line; idles high; asynchronous to `sysclk`.
- `rx_ack`  in  1  one-cycle pulse from Peripheral when it reads the data register.
- `rx_data`  out  8  last accepted byte.
- `rx_valid`  out  1  high while an unread byte is held.
- `frame_err`  out  1  sticky; the stop bit was sampled as 0.
- `overrun`  out  1  sticky; a complete byte arrived while `rx_valid`=1 and no ack arrived that cycle.
- `parity_err`  out  1  sticky; parity mismatch. Constant 0 when parity is not compiled in.

## Operation
- Reset values:
  - `rx_data`=0x00; `rx_valid`, `frame_err`, `overrun` and `parity_err` = 0.
  - FSM=IDLE; tick counter=0; synchronizer=2'b11.
- Input synchronizer: `UART_RX` passes through a two-flop synchronizer. All decisions below use the synchronized value `rxs`.
- Tick generator:
  - Counts 0..DIV-1 and emits `tick` on the wrap.
  - Held at 0 in IDLE, so the first tick after start detection is exactly DIV cycles later.
- Sample counter: 4 bits, counts ticks 0..15 within each bit.
- Bit value: majority of `rxs` at ticks 7, 8 and 9; the decision is taken at tick 9.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: on a 1→0 transition of `rxs`, go to START.
  - START: if the tick-9 decision is 1, it is a false start; return to IDLE with no flags changed. Otherwise continue to tick 15, then go to DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into a shift register. After bit 7 reaches tick 15, go to PARITY or STOP.
  - PARITY: the decided bit plus the 8 data bits must have even parity; otherwise the frame is flagged as a parity error.
  - STOP: act at the tick-9 decision, then return to IDLE immediately (half-bit early, for resync).
    - Decision 0: set `frame_err` and discard the byte.
    - Decision 1, parity good, `rx_valid`=0 or `rx_ack`=1 this cycle: load `rx_data` and set `rx_valid`.
    - Decision 1, parity bad: set `parity_err` and discard the byte.
    - Decision 1, parity good, `rx_valid`=1 and `rx_ack`=0: set `overrun`, keep the old `rx_data`, drop the new byte.
- `rx_ack`:
  - Clears `rx_valid`, `frame_err`, `overrun` and `parity_err` on the next edge.
  - If a load happens in the same cycle, the load wins: `rx_valid` stays 1 with the new data, and the sticky flags still clear.
  - An ack while `rx_valid`=0 still clears the sticky flags.
- A line held low (break): the frame ends in `frame_err`. IDLE re-arms only after `rxs` has been seen high, so a held-low line produces no repeated frames.
- Reset in mid-frame: everything returns to its reset values, and the partial byte is lost.

## Timing
- Start-edge detection: 2 `sysclk` cycles after the `UART_RX` fall (synchronizer), plus 1 cycle for edge detection.
- `rx_valid` rise, counted from the edge-detect cycle:
  - Without parity: DIV×(16×9+10) cycles, ±1.
  - With parity: DIV×(16×10+10) cycles, ±1.
- Earliest start of the next frame: the FSM is in IDLE DIV×6 cycles before the nominal stop-bit end, so back-to-back frames with a single stop bit are received.
- Tolerated baud error: ±3% accumulated over the frame.
- `rx_ack` to `rx_valid` low: 1 cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1; the PARITY state exists.
  - `parity_err` is live; bytes with bad parity are not loaded.
- Macro undefined:
  - Frame is 8N1; the PARITY state and its logic are absent.
  - `parity_err` is tied to 0.

## Test plan
- Reset and receive: `reset` low for 5 cycles, then release. Send 0xA5 at BAUD using DIV=1.
  - `rx_valid`=1 and `rx_data`=0xA5 at 154±1 cycles after edge detect.
  - All flags stay 0.
- Back-to-back and overrun: send 0x3C then 0xC3 without acking.
  - `rx_data` stays 0x3C and `overrun`=1.
  - Pulse `rx_ack`: `rx_valid`=0 and `overrun`=0 one cycle later.
- Ack collision: pulse `rx_ack` in the exact cycle the second byte loads.
  - Result: `rx_valid`=1, `rx_data`=the new byte, `overrun`=0.
- Glitch and framing:
  - A 4-tick low pulse on an idle line is a false start: no flags set, FSM back in IDLE.
  - Byte 0x55 with its stop bit forced to 0: `frame_err`=1 and `rx_valid`=0.
- Mid-frame reset: assert `reset` during bit 4 of 0xFF.
  - All outputs are 0 at once.
  - The next clean frame, 0x12, is received correctly.
- `UART_RX_PARITY_EN` defined:
  - 0x07 with parity 1: accepted.
  - 0x07 with parity 0: `parity_err`=1 and `rx_valid` unchanged.
